// File: rtl/hex_display_bank.sv
// Multi-digit hex value register with registered active-low 7-segment outputs.
// Supports load/increment, per-digit enable, leading-zero blanking and blinking.
module hex_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic                    LOAD,
    input  logic                    INC,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic                    BLANK_LZ,
    input  logic                    BLINK_EN,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [4*NUM_DIGITS-1:0] VALUE
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [VW-1:0] VALUE_ONE = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX   = CW'(BLINK_DIV - 1);

    logic [VW-1:0]         value_r;
    logic [HW-1:0]         hex_r;
    logic [CW-1:0]         blink_cnt_r;
    logic                  blink_hidden_r;

    logic [VW-1:0]         value_next_s;
    logic [HW-1:0]         hex_next_s;
    logic [CW-1:0]         blink_cnt_next_s;
    logic                  blink_hidden_next_s;
    logic [NUM_DIGITS-1:0] lead_zero_s;
    logic                  zero_run_s;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            4'hF:    glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    endfunction

    // Next value: LOAD has priority over INC; the adder wraps naturally.
    always_comb begin
        value_next_s = value_r;
        if (LOAD) begin
            value_next_s = DATA;
        end else if (INC) begin
            value_next_s = value_r + VALUE_ONE;
        end else begin
            value_next_s = value_r;
        end
    end

    // Blink divider: phase flips on the edge the counter wraps to zero.
    always_comb begin
        blink_cnt_next_s    = blink_cnt_r;
        blink_hidden_next_s = blink_hidden_r;
        if (!BLINK_EN) begin
            blink_cnt_next_s    = {CW{1'b0}};
            blink_hidden_next_s = 1'b0;
        end else if (blink_cnt_r == CNT_MAX) begin
            blink_cnt_next_s    = {CW{1'b0}};
            blink_hidden_next_s = ~blink_hidden_r;
        end else begin
            blink_cnt_next_s    = blink_cnt_r + CNT_ONE;
            blink_hidden_next_s = blink_hidden_r;
        end
    end

    // Leading-zero mask scanned from the most significant digit down.
    always_comb begin
        lead_zero_s = {NUM_DIGITS{1'b0}};
        zero_run_s  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s     = zero_run_s && (value_r[4*i +: 4] == 4'h0);
            lead_zero_s[i] = zero_run_s && (i > 0);
        end
    end

    // Per-digit glyph selection in priority order blink, enable, leading zero.
    always_comb begin
        hex_next_s = {HW{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blink_hidden_r && BLINK_EN) begin
                hex_next_s[7*i +: 7] = 7'h7F;
            end else if (!DIGIT_EN[i]) begin
                hex_next_s[7*i +: 7] = 7'h7F;
            end else if (BLANK_LZ && lead_zero_s[i]) begin
                hex_next_s[7*i +: 7] = 7'h7F;
            end else begin
                hex_next_s[7*i +: 7] = glyph(value_r[4*i +: 4]);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            value_r        <= {VW{1'b0}};
            hex_r          <= {HW{1'b1}};
            blink_cnt_r    <= {CW{1'b0}};
            blink_hidden_r <= 1'b0;
        end else begin
            value_r        <= value_next_s;
            hex_r          <= hex_next_s;
            blink_cnt_r    <= blink_cnt_next_s;
            blink_hidden_r <= blink_hidden_next_s;
        end
    end

    assign HEX   = hex_r;
    assign VALUE = value_r;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank: vector table for decode/load/inc,
// hand-written sequences for latency, blink timing and asynchronous reset.
module tb_hex_display_bank;

    localparam int ND = 6;
    localparam int BD = 4;

    logic          clk;
    logic          rst_n;
    logic [23:0]   data;
    logic          load;
    logic          inc;
    logic [5:0]    digit_en;
    logic          blank_lz;
    logic          blink_en;
    logic [41:0]   hex;
    logic [23:0]   value;

    int compared;
    int mismatched;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    localparam logic [41:0] ALL_ZERO  = {6{7'h40}};
    localparam logic [41:0] SHOW_12AB0F = {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E};

    typedef struct {
        logic        load;
        logic        inc;
        logic [23:0] data;
        logic [5:0]  en;
        logic        lz;
        logic [23:0] exp_value;
        logic [41:0] exp_hex;
    } vec_t;

    vec_t vecs [13];

    hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .DATA     (data),
        .LOAD     (load),
        .INC      (inc),
        .DIGIT_EN (digit_en),
        .BLANK_LZ (blank_lz),
        .BLINK_EN (blink_en),
        .HEX      (hex),
        .VALUE    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n    = 1'b0;
        data     = 24'h000000;
        load     = 1'b0;
        inc      = 1'b0;
        digit_en = 6'h3F;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 24'h12AB0F, 6'h3F, 1'b0, 24'h12AB0F, SHOW_12AB0F};
        vecs[1]  = '{1'b1, 1'b0, 24'hFFFFFF, 6'h3F, 1'b0, 24'hFFFFFF, {6{7'h0E}}};
        vecs[2]  = '{1'b0, 1'b1, 24'h000000, 6'h3F, 1'b0, 24'h000000, ALL_ZERO};
        vecs[3]  = '{1'b1, 1'b1, 24'h000042, 6'h3F, 1'b0, 24'h000042,
                     {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}};
        vecs[4]  = '{1'b0, 1'b0, 24'h000000, 6'h3F, 1'b1, 24'h000042,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}};
        vecs[5]  = '{1'b1, 1'b0, 24'h000000, 6'h3F, 1'b1, 24'h000000,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[6]  = '{1'b0, 1'b0, 24'h000000, 6'h3E, 1'b1, 24'h000000, ALL_BLANK};
        vecs[7]  = '{1'b1, 1'b0, 24'h305000, 6'h3F, 1'b1, 24'h305000,
                     {7'h30, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40}};
        vecs[8]  = '{1'b1, 1'b0, 24'h000100, 6'h3F, 1'b1, 24'h000100,
                     {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[9]  = '{1'b1, 1'b0, 24'h89CDE7, 6'h2A, 1'b0, 24'h89CDE7,
                     {7'h00, 7'h7F, 7'h46, 7'h7F, 7'h06, 7'h7F}};
        vecs[10] = '{1'b0, 1'b1, 24'h000000, 6'h3F, 1'b0, 24'h89CDE8,
                     {7'h00, 7'h10, 7'h46, 7'h21, 7'h06, 7'h00}};
        vecs[11] = '{1'b1, 1'b0, 24'h00FFFF, 6'h3F, 1'b1, 24'h00FFFF,
                     {7'h7F, 7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
        vecs[12] = '{1'b0, 1'b1, 24'h000000, 6'h3F, 1'b1, 24'h010000,
                     {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};

        // Reset state, then the first edge after release.
        #12;
        check("reset_hex", 64'(hex), 64'(ALL_BLANK));
        check("reset_value", 64'(value), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("release_hex", 64'(hex), 64'(ALL_ZERO));
        check("release_value", 64'(value), 64'd0);

        // Table: each vector applied for one edge, checked one edge later.
        for (int v = 0; v < 13; v++) begin
            load     = vecs[v].load;
            inc      = vecs[v].inc;
            data     = vecs[v].data;
            digit_en = vecs[v].en;
            blank_lz = vecs[v].lz;
            tick();
            load = 1'b0;
            inc  = 1'b0;
            tick();
            check($sformatf("vec%0d_value", v), 64'(value), 64'(vecs[v].exp_value));
            check($sformatf("vec%0d_hex", v), 64'(hex), 64'(vecs[v].exp_hex));
        end

        // VALUE updates at the load edge, HEX one edge later.
        load = 1'b1;
        data = 24'h000009;
        tick();
        load = 1'b0;
        check("lat_value_now", 64'(value), 64'h000009);
        check("lat_hex_old", 64'(hex), 64'({7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}));
        tick();
        check("lat_hex_new", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}));

        // Blink timing relative to edge t (BLINK_EN first sampled at t+1).
        blank_lz = 1'b0;
        load = 1'b1;
        data = 24'h12AB0F;
        tick();
        load = 1'b0;
        tick();
        blink_en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("blink_t%0d", k), 64'(hex),
                  64'((k >= 5 && k <= 8) || k == 13 ? ALL_BLANK : SHOW_12AB0F));
        end
        blink_en = 1'b0;
        tick();
        check("blink_drop", 64'(hex), 64'(SHOW_12AB0F));
        tick();
        check("blink_drop_hold", 64'(hex), 64'(SHOW_12AB0F));

        // Asynchronous reset in the middle of blink and increment activity.
        blink_en = 1'b1;
        inc      = 1'b1;
        repeat (6) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hex", 64'(hex), 64'(ALL_BLANK));
        check("async_rst_value", 64'(value), 64'd0);
        inc = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_hex", 64'(hex), 64'(ALL_BLANK));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            check($sformatf("rst_blink_r%0d", k), 64'(hex),
                  64'(k == 4 ? ALL_BLANK : ALL_ZERO));
        end
        check("rst_blink_value", 64'(value), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hex_display_bank.md
Name: hex_display_bank

Overview:
Parametrised multi-digit successor to the single-digit switch-to-7-segment decoder. Holds a NUM_DIGITS-nibble value register that can be loaded or incremented, and decodes every nibble to an active-low 7-segment glyph. Adds per-digit enable, leading-zero blanking and a clock-divided blink mode. Sits between board switches/keys or a user datapath and the DE1-SoC HEX0..HEX5 pins; all outputs are registered.

Parameters:
NUM_DIGITS, 6, number of hex digits driven; legal range 1..8.
BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 2. The default gives 1 Hz at 50 MHz.

Ports:
CLOCK_50  input  1  system clock; all state changes on the rising edge.
RESET_N  input  1  asynchronous, active-low reset.
DATA  input  4*NUM_DIGITS  value to load; nibble i (bits 4i+3:4i) drives digit i, and digit 0 is the rightmost.
LOAD  input  1  when high at a clock edge, captures DATA into the value register.
INC  input  1  when high at a clock edge (and LOAD low), increments the value register by 1.
DIGIT_EN  input  NUM_DIGITS  per-digit enable; 0 forces that digit blank.
BLANK_LZ  input  1  1 enables leading-zero blanking.
BLINK_EN  input  1  1 enables blinking of all digits.
HEX  output  7*NUM_DIGITS  segment outputs; bits 7i+6:7i are digit i, segment order gfedcba, active-low.
VALUE  output  4*NUM_DIGITS  current contents of the value register.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - value register = 0 and VALUE = 0.
  - HEX = all ones (every segment off).
  - blink counter = 0, blink phase = visible.
  - Outputs stay in this state while RESET_N is low. Reset asserted mid-blink or mid-count aborts immediately.
- Value register update, per clock edge:
  - LOAD=1: value <= DATA.
  - LOAD=0, INC=1: value <= value + 1 modulo 16^NUM_DIGITS, so all-F wraps to 0.
  - LOAD=1 and INC=1 together: LOAD wins and INC is ignored.
  - Neither asserted: value holds.
- Latency:
  - VALUE changes at the same edge that samples LOAD/INC.
  - HEX reflects the new value one edge later.
  - DIGIT_EN, BLANK_LZ and blink-phase changes also appear on HEX one edge after they are sampled or updated.
- Glyph table (7-bit hex, gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Blank = 7F.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i is blank when the nibbles of digit i and every higher digit are all 0.
  - Digit 0 is never blanked by this rule, so value 0 displays a single "0".
  - Uses the value nibbles only; DIGIT_EN does not affect which digits count as leading.
- Blink:
  - BLINK_EN=0: counter is held at 0 and phase is held at visible.
  - BLINK_EN=1: counter runs 0..BLINK_DIV-1; on the edge where it wraps to 0, the phase toggles.
  - The first hidden phase therefore begins BLINK_DIV edges after BLINK_EN rises.
  - Hidden phase blanks all digits.
  - Deasserting BLINK_EN mid-period restores visible on the next edge.
- Output priority per digit: hidden blink phase, then DIGIT_EN[i]=0, then leading-zero blank. Any one of these forces 7F; otherwise the glyph from the table is shown.
- HEX is purely registered, so there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then release with NUM_DIGITS=6, DIGIT_EN=3F, BLANK_LZ=0 -> edge after release: HEX shows six "0" glyphs (every field 40); VALUE=000000.
- LOAD=1 with DATA=0x12AB0F for one cycle -> VALUE=12AB0F at that edge; next edge HEX digits 5..0 = 79,24,08,03,40,0E.
- LOAD 0xFFFFFF then INC one cycle -> VALUE=000000. Then LOAD=1, INC=1, DATA=0x000042 -> VALUE=000042 (INC ignored).
- BLANK_LZ=1 with VALUE=0x000042 -> digits 5..2 = 7F, digit 1 = 19, digit 0 = 24. Load 0 -> only digit 0 shows 40. With DIGIT_EN=3E, digit 0 becomes 7F.
- BLINK_DIV=4, BLINK_EN raised at edge t:
  - HEX visible through t+4, all 7F from t+5 through t+8, visible again from t+9.
  - Dropping BLINK_EN during the hidden phase restores the glyphs one edge later.
- Assert RESET_N low asynchronously between edges during blink and INC activity -> HEX=all 7F and VALUE=0 immediately; after release the blink counter restarts from 0.
